// File: rtl/spi_ctrl_reg_fsm.sv
// SPI control register with a one-shot transaction sequencer.
// A write with send=1 strobes start, waits for tx_done, then pulses done and clears send.
module spi_ctrl_reg_fsm #(
  parameter int unsigned N    = 5,
  parameter int unsigned CS_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     i_data,
  input  logic            wr2_c,
  input  logic            tx_done,
  input  logic            rx_inc,
  output logic [31:0]     o_data,
  output logic            send,
  output logic            cs_ctrl,
  output logic            all_1s,
  output logic            all_0s,
  output logic [N:0]      n_tx_end,
  output logic [N+1:0]    n_rx_end,
  output logic [CS_W-1:0] cs_sel,
  output logic            start,
  output logic            busy,
  output logic            done,
  output logic [N+1:0]    rx_cnt,
  output logic            wr_err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StBusy  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Bits that exist in the control word; everything else is never stored and reads 0.
  localparam logic [31:0] CtrlMask = 32'h0000_000F
                                   | (((32'd1 << (N + 1)) - 32'd1) << 4)
                                   | (((32'd1 << (N + 2)) - 32'd1) << 16)
                                   | (((32'd1 << CS_W) - 32'd1) << 28);

  localparam logic [N+1:0] RxOne = 1;

  logic [1:0]   state_q, state_d;
  logic [31:0]  ctrl_q, ctrl_d;
  logic [N+1:0] rx_cnt_q, rx_cnt_d;
  logic         wr_err_q, wr_err_d;
  logic         wr_ok;

  assign wr_ok = wr2_c && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ctrl_q[0]) state_d = StStart;
      StStart: state_d = StBusy;
      StBusy:  if (tx_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ok) begin
      ctrl_d = i_data & CtrlMask;
    end
    // Writes are impossible in DONE, so the hardware clear never races a bus write.
    if (state_q == StDone) begin
      ctrl_d[0] = 1'b0;
    end
  end

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (state_q == StIdle && ctrl_q[0]) begin
      rx_cnt_d = '0;
    end else if (state_q == StBusy && rx_inc && rx_cnt_q != '1) begin
      rx_cnt_d = rx_cnt_q + RxOne;
    end
  end

  assign wr_err_d = wr2_c && (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ctrl_q   <= '0;
      rx_cnt_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      rx_cnt_q <= rx_cnt_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign o_data   = ctrl_q;
  assign send     = ctrl_q[0];
  assign cs_ctrl  = ctrl_q[1];
  assign all_1s   = ctrl_q[2];
  assign all_0s   = ctrl_q[3];
  assign n_tx_end = ctrl_q[4+N:4];
  assign n_rx_end = ctrl_q[17+N:16];
  assign cs_sel   = ctrl_q[27+CS_W:28];

  assign start  = (state_q == StStart);
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign rx_cnt = rx_cnt_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_spi_ctrl_reg_fsm.sv
// Bench for spi_ctrl_reg_fsm: two instances (N=5 and N=4) share stimulus and are checked
// against a transaction-level model of the control word and receive count.
module tb_spi_ctrl_reg_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data;
  logic        wr2_c, tx_done, rx_inc;

  logic [31:0] a_o_data, b_o_data;
  logic        a_send, a_cs_ctrl, a_all_1s, a_all_0s, a_start, a_busy, a_done, a_wr_err;
  logic        b_send, b_cs_ctrl, b_all_1s, b_all_0s, b_start, b_busy, b_done, b_wr_err;
  logic [5:0]  a_n_tx_end;
  logic [6:0]  a_n_rx_end, a_rx_cnt;
  logic [4:0]  b_n_tx_end;
  logic [5:0]  b_n_rx_end, b_rx_cnt;
  logic [1:0]  a_cs_sel, b_cs_sel;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_word [2];
  int          m_rx   [2];

  always #5 clk = ~clk;

  spi_ctrl_reg_fsm #(.N(5), .CS_W(2)) u_dut (
    .clk(clk), .rst(rst), .i_data(i_data), .wr2_c(wr2_c), .tx_done(tx_done),
    .rx_inc(rx_inc), .o_data(a_o_data), .send(a_send), .cs_ctrl(a_cs_ctrl),
    .all_1s(a_all_1s), .all_0s(a_all_0s), .n_tx_end(a_n_tx_end), .n_rx_end(a_n_rx_end),
    .cs_sel(a_cs_sel), .start(a_start), .busy(a_busy), .done(a_done), .rx_cnt(a_rx_cnt),
    .wr_err(a_wr_err)
  );

  spi_ctrl_reg_fsm #(.N(4), .CS_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .i_data(i_data), .wr2_c(wr2_c), .tx_done(tx_done),
    .rx_inc(rx_inc), .o_data(b_o_data), .send(b_send), .cs_ctrl(b_cs_ctrl),
    .all_1s(b_all_1s), .all_0s(b_all_0s), .n_tx_end(b_n_tx_end), .n_rx_end(b_n_rx_end),
    .cs_sel(b_cs_sel), .start(b_start), .busy(b_busy), .done(b_done), .rx_cnt(b_rx_cnt),
    .wr_err(b_wr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] field_mask(input int n);
    return 32'hF | (((32'd1 << (n + 1)) - 1) << 4) | (((32'd1 << (n + 2)) - 1) << 16)
         | (32'h3 << 28);
  endfunction

  function automatic int n_of(input int i);
    return (i == 0) ? 5 : 4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [31:0] d);
    for (int i = 0; i < 2; i++) m_word[i] = d & field_mask(n_of(i));
  endtask

  task automatic model_rx();
    for (int i = 0; i < 2; i++) begin
      int sat;
      sat = (1 << (n_of(i) + 2)) - 1;
      if (m_rx[i] < sat) m_rx[i]++;
    end
  endtask

  task automatic chk_all(input string tag, input bit e_start, input bit e_busy,
                         input bit e_done, input bit e_err);
    for (int i = 0; i < 2; i++) begin
      int          n;
      logic [31:0] w;
      string       t;
      n = n_of(i);
      w = m_word[i];
      t = $sformatf("%s[N=%0d]", tag, n);
      check({t, ".o_data"}, (i == 0) ? a_o_data : b_o_data, w);
      check({t, ".send"}, 32'((i == 0) ? a_send : b_send), 32'(w[0]));
      check({t, ".cs_ctrl"}, 32'((i == 0) ? a_cs_ctrl : b_cs_ctrl), 32'(w[1]));
      check({t, ".all_1s"}, 32'((i == 0) ? a_all_1s : b_all_1s), 32'(w[2]));
      check({t, ".all_0s"}, 32'((i == 0) ? a_all_0s : b_all_0s), 32'(w[3]));
      check({t, ".n_tx_end"}, (i == 0) ? 32'(a_n_tx_end) : 32'(b_n_tx_end),
            (w >> 4) & ((32'd1 << (n + 1)) - 1));
      check({t, ".n_rx_end"}, (i == 0) ? 32'(a_n_rx_end) : 32'(b_n_rx_end),
            (w >> 16) & ((32'd1 << (n + 2)) - 1));
      check({t, ".cs_sel"}, 32'((i == 0) ? a_cs_sel : b_cs_sel), (w >> 28) & 32'h3);
      check({t, ".start"}, 32'((i == 0) ? a_start : b_start), 32'(e_start));
      check({t, ".busy"}, 32'((i == 0) ? a_busy : b_busy), 32'(e_busy));
      check({t, ".done"}, 32'((i == 0) ? a_done : b_done), 32'(e_done));
      check({t, ".wr_err"}, 32'((i == 0) ? a_wr_err : b_wr_err), 32'(e_err));
      check({t, ".rx_cnt"}, (i == 0) ? 32'(a_rx_cnt) : 32'(b_rx_cnt), 32'(m_rx[i]));
    end
  endtask

  // Launch a transfer up to the first BUSY cycle; returns with inputs idle.
  task automatic launch(input logic [31:0] d);
    i_data = d;
    wr2_c  = 1'b1;
    step();
    wr2_c = 1'b0;
    model_write(d);
    chk_all("wr", 0, 0, 0, 0);
    rx_inc = 1'($urandom_range(0, 1));  // sampled in IDLE: ignored
    step();
    for (int i = 0; i < 2; i++) m_rx[i] = 0;
    chk_all("start", 1, 1, 0, 0);
    rx_inc = 1'($urandom_range(0, 1));  // sampled in START: ignored
    step();
    rx_inc = 1'b0;
    chk_all("busy0", 0, 1, 0, 0);
  endtask

  task automatic pulses(input int k);
    for (int p = 0; p < k; p++) begin
      rx_inc = 1'b1;
      step();
      rx_inc = 1'b0;
      model_rx();
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  task automatic run_txn(input logic [31:0] d, input int k, input bit bad, input bit both);
    launch(d | 32'h1);
    pulses(k);
    chk_all("count", 0, 1, 0, 0);
    if (bad) begin
      i_data = $urandom;
      wr2_c  = 1'b1;
      step();
      wr2_c = 1'b0;
      chk_all("wr_busy", 0, 1, 0, 1);
      step();
      chk_all("wr_busy+1", 0, 1, 0, 0);
    end
    tx_done = 1'b1;
    rx_inc  = both;
    step();
    tx_done = 1'b0;
    rx_inc  = 1'b0;
    if (both) model_rx();
    chk_all("done", 0, 1, 1, 0);
    step();
    for (int i = 0; i < 2; i++) m_word[i][0] = 1'b0;
    chk_all("idle", 0, 0, 0, 0);
  endtask

  initial begin
    rst     = 1'b0;
    i_data  = '0;
    wr2_c   = 1'b0;
    tx_done = 1'b0;
    rx_inc  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_word[i] = '0;
      m_rx[i]   = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk_all("post_reset", 0, 0, 0, 0);

    run_txn(32'h1003_0151, 3, 1'b1, 1'b0);
    check("dir.cs_sel", 32'(a_cs_sel), 32'd1);
    check("dir.n_tx_end", 32'(a_n_tx_end), 32'h15);
    check("dir.n_rx_end", 32'(a_n_rx_end), 32'h03);
    check("dir.cs_ctrl", 32'(a_cs_ctrl), 32'd0);
    check("dir.rx_cnt", 32'(a_rx_cnt), 32'd3);

    // Config-only write: no transfer may start.
    i_data = $urandom & 32'hFFFF_FFFE;
    wr2_c  = 1'b1;
    step();
    wr2_c = 1'b0;
    model_write(i_data);
    for (int c = 0; c < 3; c++) begin
      chk_all("cfg_only", 0, 0, 0, 0);
      step();
    end

    // Strobes outside BUSY are ignored.
    tx_done = 1'b1;
    rx_inc  = 1'b1;
    step();
    tx_done = 1'b0;
    rx_inc  = 1'b0;
    chk_all("idle_strobes", 0, 0, 0, 0);

    run_txn($urandom, 70, 1'b0, 1'b1);
    for (int t = 0; t < 6; t++) begin
      run_txn($urandom, $urandom_range(0, 10), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a transfer.
    launch($urandom | 32'h1);
    pulses(2);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      m_word[i] = '0;
      m_rx[i]   = 0;
    end
    chk_all("rst_mid", 0, 0, 0, 0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk_all("rst_hold", 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk_all("rst_after", 0, 0, 0, 0);
    run_txn($urandom, 4, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
